// File: rtl/estop_ctrl_if.sv
// Signal bundle between the E-stop supervisor and its surroundings: raw button/request
// inputs toward the supervisor, chain status and SSR enable back out.
interface estop_ctrl_if;
    logic estop_btn1_no;
    logic estop_btn2_no;
    logic diag_activation;
    logic teensy_activation;
    logic estop_open;
    logic ssr_enable;
    logic estop_fault;

    modport master (
        output estop_btn1_no, estop_btn2_no, diag_activation, teensy_activation,
        input  estop_open, ssr_enable, estop_fault
    );

    modport slave (
        input  estop_btn1_no, estop_btn2_no, diag_activation, teensy_activation,
        output estop_open, ssr_enable, estop_fault
    );
endinterface

// File: rtl/estop_ctrl.sv
// E-stop supervisor: synchronises/debounces two buttons, latches trips, re-arms on a Teensy edge,
// and runs a timed diagnostic SSR-open window. Define ESTOP_DUAL_CHANNEL_CHECK_EN for the discrepancy fault.
module estop_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES    = 10000,
    parameter int unsigned DIAG_CYCLES        = 1000,
    parameter int unsigned DISCREPANCY_CYCLES = 50000
) (
    input  logic        clk_1m,
    input  logic        rst_n,
    estop_ctrl_if.slave bus
);
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned DIAG_W = (DIAG_CYCLES > 1) ? $clog2(DIAG_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIAG_W-1:0] DIAG_LAST = DIAG_W'(DIAG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DIAG_CYCLES < 2 || DISCREPANCY_CYCLES < 2) begin : g_bad_params
        $error("estop_ctrl: all cycle parameters must be at least 2");
    end

    typedef enum logic [1:0] {SAFE, ARMED, DIAG, TRIPPED} state_t;

    logic [3:0]        raw_in;
    logic [3:0]        sync1_reg;
    logic [3:0]        sync2_reg;
    logic [1:0]        act_prev_reg;
    logic              diag_edge;
    logic              teensy_edge;
    logic              pressed;
    logic              fault;
    state_t            state_reg;
    logic [DIAG_W-1:0] diag_cnt_reg;
    logic              ssr_enable_reg;
    logic              estop_open_reg;

    // Bit order: [0] btn1, [1] btn2, [2] diag, [3] teensy
    assign raw_in = {bus.teensy_activation, bus.diag_activation, bus.estop_btn2_no, bus.estop_btn1_no};

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= '0;
            sync2_reg    <= '0;
            act_prev_reg <= '0;
        end else begin
            sync1_reg    <= raw_in;
            sync2_reg    <= sync1_reg;
            act_prev_reg <= sync2_reg[3:2];
        end
    end

    assign diag_edge   = sync2_reg[2] & ~act_prev_reg[0];
    assign teensy_edge = sync2_reg[3] & ~act_prev_reg[1];

    // The debounced value only follows after DEBOUNCE_CYCLES consecutive differing samples
    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        logic            db_reg;
        logic [DB_W-1:0] cnt_reg;

        always_ff @(posedge clk_1m or negedge rst_n) begin
            if (!rst_n) begin
                db_reg  <= 1'b0;
                cnt_reg <= '0;
            end else if (sync2_reg[gi] != db_reg) begin
                if (cnt_reg == DB_LAST) begin
                    db_reg  <= sync2_reg[gi];
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign pressed = g_db[0].db_reg | g_db[1].db_reg;

`ifdef ESTOP_DUAL_CHANNEL_CHECK_EN
    localparam int unsigned DISC_W = (DISCREPANCY_CYCLES > 1) ? $clog2(DISCREPANCY_CYCLES) : 1;
    localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISCREPANCY_CYCLES - 1);

    logic [DISC_W-1:0] disc_cnt_reg;
    logic              fault_reg;

    // Fault is sticky until reset; the counter holds at its last value once tripped
    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            disc_cnt_reg <= '0;
            fault_reg    <= 1'b0;
        end else if (g_db[0].db_reg != g_db[1].db_reg) begin
            if (disc_cnt_reg == DISC_LAST) begin
                fault_reg <= 1'b1;
            end else begin
                disc_cnt_reg <= disc_cnt_reg + 1'b1;
            end
        end else begin
            disc_cnt_reg <= '0;
        end
    end

    assign fault = fault_reg;
`else
    assign fault = 1'b0;
`endif

    // Outputs are registered alongside the state so they change on the same edge
    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= SAFE;
            diag_cnt_reg   <= '0;
            ssr_enable_reg <= 1'b0;
            estop_open_reg <= 1'b0;
        end else begin
            case (state_reg)
                SAFE: begin
                    if (pressed) begin
                        state_reg      <= TRIPPED;
                        estop_open_reg <= 1'b1;
                    end else if (teensy_edge && !fault) begin
                        state_reg      <= ARMED;
                        ssr_enable_reg <= 1'b1;
                    end
                end
                ARMED: begin
                    if (pressed) begin
                        state_reg      <= TRIPPED;
                        ssr_enable_reg <= 1'b0;
                        estop_open_reg <= 1'b1;
                    end else if (fault) begin
                        state_reg      <= SAFE;
                        ssr_enable_reg <= 1'b0;
                    end else if (diag_edge) begin
                        state_reg      <= DIAG;
                        diag_cnt_reg   <= DIAG_LAST;
                        ssr_enable_reg <= 1'b0;
                    end
                end
                DIAG: begin
                    if (pressed) begin
                        state_reg      <= TRIPPED;
                        estop_open_reg <= 1'b1;
                    end else if (fault) begin
                        state_reg <= SAFE;
                    end else if (diag_cnt_reg == '0) begin
                        state_reg      <= ARMED;
                        ssr_enable_reg <= 1'b1;
                    end else begin
                        diag_cnt_reg <= diag_cnt_reg - 1'b1;
                    end
                end
                TRIPPED: begin
                    if (!pressed) begin
                        state_reg      <= SAFE;
                        estop_open_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= SAFE;
                    ssr_enable_reg <= 1'b0;
                    estop_open_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ssr_enable  = ssr_enable_reg;
    assign bus.estop_open  = estop_open_reg;
    assign bus.estop_fault = fault;
endmodule

// File: tb/tb_estop_ctrl.sv
// Directed bench for estop_ctrl with short sim parameters; expectations go through a scoreboard queue.
`timescale 1ns/1ps
module tb_estop_ctrl;
    logic clk_1m = 1'b0;
    logic rst_n  = 1'b0;

    estop_ctrl_if bus ();

    estop_ctrl #(
        .DEBOUNCE_CYCLES   (4),
        .DIAG_CYCLES       (8),
        .DISCREPANCY_CYCLES(16)
    ) dut (
        .clk_1m(clk_1m),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk_1m = ~clk_1m;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    localparam int SSR = 0;
    localparam int OPEN = 1;
    localparam int FLT = 2;

    function automatic logic [31:0] get(input int sel);
        case (sel)
            SSR:     return 32'(bus.ssr_enable);
            OPEN:    return 32'(bus.estop_open);
            default: return 32'(bus.estop_fault);
        endcase
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: observed=%0d expected=none", obs);
            return;
        end
        e = sb.pop_front();
        $display("check %-16s observed=%0d expected=%0d", e.tag, obs, e.exp);
        assert (obs === e.exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    // Waits up to budget falling edges for the signal to reach the queued value, then compares
    task automatic wait_check(input string tag, input int sel, input logic v, input int budget);
        expect_val(tag, 32'(v));
        for (int i = 0; i < budget && get(sel) !== 32'(v); i++) @(negedge clk_1m);
        check(get(sel));
    endtask

    task automatic pulse_teensy();
        bus.teensy_activation = 1'b1;
        repeat (3) @(negedge clk_1m);
        bus.teensy_activation = 1'b0;
    endtask

    task automatic pulse_diag();
        bus.diag_activation = 1'b1;
        repeat (2) @(negedge clk_1m);
        bus.diag_activation = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bus.estop_btn1_no     = 1'b0;
        bus.estop_btn2_no     = 1'b0;
        bus.diag_activation   = 1'b0;
        bus.teensy_activation = 1'b0;
        repeat (3) @(negedge clk_1m);

        // Reset state
        expect_val("rst_ssr", 0);   check(get(SSR));
        expect_val("rst_open", 0);  check(get(OPEN));
        expect_val("rst_fault", 0); check(get(FLT));
        rst_n = 1'b1;
        repeat (3) @(negedge clk_1m);

        // 1: arm from SAFE
        expect_val("safe_ssr", 0);  check(get(SSR));
        expect_val("safe_open", 0); check(get(OPEN));
        pulse_teensy();
        wait_check("arm_ssr", SSR, 1'b1, 4);

        // 2: trip on btn1, stays off after release
        bus.estop_btn1_no = 1'b1;
        wait_check("trip_ssr", SSR, 1'b0, 8);
        expect_val("trip_open", 1); check(get(OPEN));
        bus.estop_btn1_no = 1'b0;
        wait_check("release_open", OPEN, 1'b0, 10);
        repeat (10) @(negedge clk_1m);
        expect_val("no_autoarm", 0); check(get(SSR));
        pulse_teensy();
        wait_check("rearm1_ssr", SSR, 1'b1, 4);

        // 3: short glitch rejected
        bus.estop_btn2_no = 1'b1;
        repeat (2) @(negedge clk_1m);
        bus.estop_btn2_no = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_1m);
            if (bus.ssr_enable !== 1'b1) cnt++;
        end
        expect_val("glitch_lowcnt", 0); check(32'(cnt));

        // 4: diag window is exactly 8 cycles
        pulse_diag();
        wait_check("diag_ssr_off", SSR, 1'b0, 6);
        cnt = 0;
        for (int i = 0; i < 20 && bus.ssr_enable === 1'b0; i++) begin
            cnt++;
            @(negedge clk_1m);
        end
        expect_val("diag_len", 8);   check(32'(cnt));
        expect_val("diag_back", 1);  check(get(SSR));
        expect_val("diag_open", 0);  check(get(OPEN));
        repeat (3) @(negedge clk_1m);
        bus.estop_btn2_no = 1'b1;
        pulse_diag();
        wait_check("diag_trip_open", OPEN, 1'b1, 10);
        expect_val("diag_trip_ssr", 0); check(get(SSR));
        bus.estop_btn2_no = 1'b0;
        wait_check("diag_rel_open", OPEN, 1'b0, 10);
        pulse_teensy();
        wait_check("rearm2_ssr", SSR, 1'b1, 4);

        // 5: teensy edge while pressed is ignored and forgotten
        bus.estop_btn1_no = 1'b1;
        bus.estop_btn2_no = 1'b1;
        wait_check("hold_open", OPEN, 1'b1, 10);
        pulse_teensy();
        repeat (3) @(negedge clk_1m);
        expect_val("held_ssr", 0); check(get(SSR));
        bus.estop_btn1_no = 1'b0;
        bus.estop_btn2_no = 1'b0;
        wait_check("held_rel_open", OPEN, 1'b0, 10);
        repeat (8) @(negedge clk_1m);
        expect_val("no_memory_ssr", 0); check(get(SSR));
        pulse_teensy();
        wait_check("rearm3_ssr", SSR, 1'b1, 4);
        repeat (2) @(negedge clk_1m);
        #2 rst_n = 1'b0;
        #1;
        expect_val("async_rst_ssr", 0);  check(get(SSR));
        expect_val("async_rst_open", 0); check(get(OPEN));
        @(negedge clk_1m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_1m);

        // 6: single-channel hold
        bus.estop_btn1_no = 1'b1;
        repeat (30) @(negedge clk_1m);
        expect_val("disc_open", 1); check(get(OPEN));
`ifdef ESTOP_DUAL_CHANNEL_CHECK_EN
        expect_val("disc_fault", 1); check(get(FLT));
        bus.estop_btn1_no = 1'b0;
        wait_check("disc_rel_open", OPEN, 1'b0, 10);
        pulse_teensy();
        repeat (6) @(negedge clk_1m);
        expect_val("fault_blocks", 0); check(get(SSR));
        expect_val("fault_sticky", 1); check(get(FLT));
        rst_n = 1'b0;
        #1;
        expect_val("fault_rst", 0); check(get(FLT));
        @(negedge clk_1m);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_1m);
`else
        expect_val("nofault", 0); check(get(FLT));
        bus.estop_btn1_no = 1'b0;
        wait_check("disc_rel_open", OPEN, 1'b0, 10);
        pulse_teensy();
        wait_check("rearm4_ssr", SSR, 1'b1, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
